audio_frame_buffer: RTL and testbench

- Upstream feeder of the stereo audio data serializer. It takes interleaved 32-bit mono sample words (left, then right) from the DMA/sample-producer AXI-Stream.
- Packs each left/right pair into one 64-bit stereo frame and buffers frames in a synchronous FIFO.
- Presents frames to the serializer on a 64-bit stream. Handles priming, underrun fill and channel-misalignment recovery, all in the ac_bclk domain.

---
 rtl/audio_buffer_pkg.sv | 28 ++
 rtl/audio_frame_fifo.sv | 61 ++++++
 rtl/audio_frame_buffer.sv | 132 +++++++++++++
 tb/tb_audio_frame_buffer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_buffer_pkg.sv
// Shared types and widths for the stereo audio frame buffer.
package audio_buffer_pkg;

  localparam int FRAME_W  = 64;
  localparam int SAMPLE_W = 32;

  typedef enum logic [1:0] {
    FILL_NONE   = 2'b00,
    FILL_ZERO   = 2'b01,
    FILL_REPEAT = 2'b10
  } fill_mode_t;

  typedef enum logic [1:0] {
    PRIME    = 2'b00,
    STREAM   = 2'b01,
    UNDERRUN = 2'b10
  } buf_state_t;

  // The unused encoding 2'b11 behaves as a zero fill.
  function automatic fill_mode_t decode_fill(input logic [1:0] mode);
    case (mode)
      2'b00:   return FILL_NONE;
      2'b10:   return FILL_REPEAT;
      default: return FILL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous show-ahead frame FIFO; the head word is visible on rdata
// whenever the FIFO is not empty.
module audio_frame_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     ac_bclk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_next;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign empty   = (level == '0);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    level_next = level;
    if (push_ok && !pop_ok)
      level_next = level + (AW+1)'(1);
    else if (pop_ok && !push_ok)
      level_next = level - (AW+1)'(1);
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge ac_bclk) begin
    if (reset_n && !flush && push_ok)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge ac_bclk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
      full  <= (level_next == (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/audio_frame_buffer.sv
// Packs left/right sample words into stereo frames, buffers them and feeds
// the serializer with priming, underrun fill and misalignment recovery.
module audio_frame_buffer
  import audio_buffer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 4,
  parameter int CNT_W       = 16
) (
  input  logic                          ac_bclk,
  input  logic                          reset_n,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [SAMPLE_W-1:0]           s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [FRAME_W-1:0]            m_axis_tdata,
  input  logic [1:0]                    fill_mode,
  input  logic                          flush,
  input  logic                          clear_counters,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              underrun_count,
  output logic [CNT_W-1:0]              misalign_count,
  output logic                          streaming
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0] PRIME_LVL = LVL_W'(PRIME_LEVEL);

  buf_state_t           state;
  fill_mode_t           fill_eff;
  logic [1:0]           fill_q;
  logic                 run_q;
  logic                 hold_valid;
  logic [SAMPLE_W-1:0]  hold_data;
  logic [FRAME_W-1:0]   last_frame;
  logic [FRAME_W-1:0]   head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 orphan;
  logic                 fill_taken;

  assign fill_eff  = decode_fill(fill_q);
  assign streaming = (state == STREAM);

  // run_q keeps input closed for the first cycle out of reset.
  assign s_axis_tready = reset_n & run_q & ~flush & (~hold_valid | ~fifo_full);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign push          = accept & s_axis_tlast & hold_valid;
  assign orphan        = accept & (s_axis_tlast ^ hold_valid);
  assign pop           = (state == STREAM) & m_axis_tready & ~flush & ~fifo_empty;
  assign fill_taken    = (state == UNDERRUN) & m_axis_tvalid & m_axis_tready & ~flush;

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    if (state == STREAM) begin
      m_axis_tvalid = 1'b1;
      m_axis_tdata  = head;
    end else begin
      m_axis_tvalid = (fill_eff != FILL_NONE);
      if (state == UNDERRUN && fill_eff == FILL_REPEAT)
        m_axis_tdata = last_frame;
    end
  end

  audio_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_W)
  ) u_fifo (
    .ac_bclk (ac_bclk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push),
    .wdata   ({s_axis_tdata, hold_data}),
    .pop     (pop),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge ac_bclk) begin
    if (!reset_n) begin
      state          <= PRIME;
      fill_q         <= 2'b00;
      run_q          <= 1'b0;
      hold_valid     <= 1'b0;
      hold_data      <= '0;
      last_frame     <= '0;
      underrun_count <= '0;
      misalign_count <= '0;
    end else begin
      run_q  <= 1'b1;
      fill_q <= fill_mode;

      if (clear_counters) begin
        underrun_count <= '0;
        misalign_count <= '0;
      end else begin
        if (fill_taken && underrun_count != '1)
          underrun_count <= underrun_count + CNT_W'(1);
        if (orphan && misalign_count != '1)
          misalign_count <= misalign_count + CNT_W'(1);
      end

      if (flush) begin
        hold_valid <= 1'b0;
        state      <= PRIME;
      end else begin
        if (accept) begin
          hold_valid <= ~s_axis_tlast;
          if (!s_axis_tlast)
            hold_data <= s_axis_tdata;
        end
        if (pop)
          last_frame <= head;
        // A same-cycle push keeps the FIFO non-empty, so only a lone final pop underruns.
        case (state)
          PRIME, UNDERRUN: if (fifo_level >= PRIME_LVL) state <= STREAM;
          STREAM:          if (pop && !push && fifo_level == LVL_W'(1)) state <= UNDERRUN;
          default:         state <= PRIME;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a queue-based model of the frame buffer.
module tb_audio_frame_buffer;

  localparam int DEPTH = 16;
  localparam int PL    = 4;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int M_PRIME = 0, M_STREAM = 1, M_UNDER = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [1:0]  fill_mode;
  logic        flush;
  logic        clear_counters;
  logic [4:0]  fifo_level;
  logic [CW-1:0] underrun_count;
  logic [CW-1:0] misalign_count;
  logic        streaming;

  int n_checks = 0;
  int n_fail   = 0;

  audio_frame_buffer #(.FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PL), .CNT_W(CW)) dut (
    .ac_bclk        (clk),
    .reset_n        (reset_n),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .fill_mode      (fill_mode),
    .flush          (flush),
    .clear_counters (clear_counters),
    .fifo_level     (fifo_level),
    .underrun_count (underrun_count),
    .misalign_count (misalign_count),
    .streaming      (streaming)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] q[$];
  bit          hold_v;
  logic [31:0] hold_d;
  logic [63:0] last_m;
  int          mode_m;
  int          urc, mis;
  logic [1:0]  fill_m;
  bit          run_m;
  bit          chk_en = 0;
  bit          m_acc, m_pop, m_fillc, m_orph, m_push;
  int          m_lvl0;
  logic [63:0] m_frame;

  function automatic int eff_fill();
    return (fill_m == 2'b11) ? 1 : int'(fill_m);
  endfunction

  function automatic bit exp_ready();
    return reset_n && run_m && !flush && (!hold_v || q.size() < DEPTH);
  endfunction

  function automatic bit exp_valid();
    return (mode_m == M_STREAM) || (eff_fill() != 0);
  endfunction

  function automatic logic [63:0] exp_data();
    if (mode_m == M_STREAM) return q[0];
    if (mode_m == M_UNDER && eff_fill() == 2) return last_m;
    return 64'h0;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      q.delete();
      hold_v = 0; hold_d = '0; last_m = '0; mode_m = M_PRIME;
      urc = 0; mis = 0; fill_m = 2'b00; run_m = 0; chk_en = 1;
    end else begin
      m_acc   = s_axis_tvalid && exp_ready();
      m_pop   = !flush && mode_m == M_STREAM && m_axis_tready;
      m_fillc = !flush && mode_m == M_UNDER && eff_fill() != 0 && m_axis_tready;
      m_orph  = 0;
      m_push  = 0;
      if (m_acc) begin
        if (!s_axis_tlast) begin
          if (hold_v) m_orph = 1;
          hold_v = 1;
          hold_d = s_axis_tdata;
        end else if (hold_v) begin
          m_push  = 1;
          m_frame = {s_axis_tdata, hold_d};
          hold_v  = 0;
        end else begin
          m_orph = 1;
        end
      end
      m_lvl0 = q.size();
      if (flush) begin
        q.delete();
        hold_v = 0;
        mode_m = M_PRIME;
      end else begin
        if (m_pop) last_m = q.pop_front();
        if (m_push) q.push_back(m_frame);
        if (mode_m != M_STREAM) begin
          if (m_lvl0 >= PL) mode_m = M_STREAM;
        end else if (m_pop && q.size() == 0) begin
          mode_m = M_UNDER;
        end
      end
      if (clear_counters) begin
        urc = 0; mis = 0;
      end else begin
        if (m_fillc && urc < CMAX) urc++;
        if (m_orph && mis < CMAX) mis++;
      end
      fill_m = fill_mode;
      run_m  = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_axis_tready", s_axis_tready, exp_ready());
      chk("m_axis_tvalid", m_axis_tvalid, exp_valid());
      if (exp_valid()) chk("m_axis_tdata", m_axis_tdata, exp_data());
      chk("fifo_level", fifo_level, 64'(q.size()));
      chk("underrun_count", underrun_count, 64'(urc));
      chk("misalign_count", misalign_count, 64'(mis));
      chk("streaming", streaming, 64'(mode_m == M_STREAM));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic l);
    bit ok = 0;
    s_axis_tvalid = 1; s_axis_tdata = d; s_axis_tlast = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 0; s_axis_tlast = 0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: word %h never accepted", d);
    end
  endtask

  task automatic push_pair(input int i);
    logic [31:0] k;
    k = 32'(i);
    push_word(32'h11111111 * k, 1'b0);
    push_word(32'h22222222 * k, 1'b1);
  endtask

  task automatic pulse_ready();
    m_axis_tready = 1;
    tick();
    m_axis_tready = 0;
  endtask

  bit ph;

  initial begin
    reset_n = 0; s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tlast = 0;
    m_axis_tready = 0; fill_mode = 2'b00; flush = 0; clear_counters = 0;
    tick(); tick();
    @(negedge clk);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_counts", {underrun_count, misalign_count}, 0);
    chk("rst_streaming", streaming, 0);
    @(posedge clk); #1;
    reset_n = 1;

    // Priming
    for (int i = 1; i <= 3; i++) push_pair(i);
    @(negedge clk);
    chk("prime_tvalid", m_axis_tvalid, 0);
    chk("prime_level", fifo_level, 3);
    @(posedge clk); #1;
    push_pair(4);
    @(negedge clk);
    chk("prime4_not_yet", streaming, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stream_first_tdata", m_axis_tdata, 64'h2222222211111111);
    chk("stream_first_on", streaming, 1);
    @(posedge clk); #1;

    // Drain, then repeat-fill underrun
    fill_mode = 2'b10;
    for (int i = 0; i < 4; i++) pulse_ready();
    for (int i = 0; i < 3; i++) pulse_ready();
    @(negedge clk);
    chk("repeat_tdata", m_axis_tdata, 64'h8888888844444444);
    chk("underrun_3", underrun_count, 3);
    chk("underrun_state", streaming, 0);
    @(posedge clk); #1;
    for (int i = 5; i <= 7; i++) push_pair(i);
    tick();
    @(negedge clk);
    chk("resume_wait", streaming, 0);
    @(posedge clk); #1;
    push_pair(8);
    tick();
    @(negedge clk);
    chk("resume_stream", streaming, 1);
    chk("resume_tdata", m_axis_tdata, 64'hAAAAAAAA55555555);
    @(posedge clk); #1;

    // Flush with five frames
    push_pair(9);
    @(negedge clk);
    chk("preflush_level", fifo_level, 5);
    @(posedge clk); #1;
    fill_mode = 2'b00; flush = 1;
    tick();
    flush = 0;
    @(negedge clk);
    chk("flush_level", fifo_level, 0);
    chk("flush_state", streaming, 0);
    chk("flush_tvalid", m_axis_tvalid, 0);
    chk("flush_underrun", underrun_count, 3);
    @(posedge clk); #1;

    // Full FIFO back-pressure, no frame lost
    for (int i = 1; i <= 16; i++) begin
      push_word(32'hA0000000 + 32'(i), 1'b0);
      push_word(32'hB0000000 + 32'(i), 1'b1);
    end
    push_word(32'hA0000011, 1'b0);
    s_axis_tvalid = 1; s_axis_tdata = 32'hB0000011; s_axis_tlast = 1;
    @(negedge clk);
    chk("full_level", fifo_level, 16);
    chk("full_tready", s_axis_tready, 0);
    chk("full_head", m_axis_tdata, 64'hB0000001A0000001);
    @(posedge clk); #1;
    pulse_ready();
    @(negedge clk);
    chk("after_pop_tready", s_axis_tready, 1);
    @(posedge clk); #1;
    s_axis_tvalid = 0; s_axis_tlast = 0;
    @(negedge clk);
    chk("refill_level", fifo_level, 16);
    @(posedge clk); #1;
    for (int i = 2; i <= 17; i++) begin
      @(negedge clk);
      chk("drain_order", m_axis_tdata, {32'hB0000000 + 32'(i), 32'hA0000000 + 32'(i)});
      @(posedge clk); #1;
      pulse_ready();
    end

    // Misalignment recovery
    flush = 1; tick(); flush = 0;
    push_word(32'h12345678, 1'b0);
    push_word(32'hAAAA0000, 1'b0);
    push_word(32'hBBBB0000, 1'b1);
    for (int i = 1; i <= 3; i++) push_pair(i);
    tick();
    @(negedge clk);
    chk("misalign_1", misalign_count, 1);
    chk("misalign_frame", m_axis_tdata, 64'hBBBB0000AAAA0000);
    @(posedge clk); #1;
    push_word(32'hCCCCCCCC, 1'b1);
    @(negedge clk);
    chk("misalign_2", misalign_count, 2);
    @(posedge clk); #1;

    // One-cycle reset mid-stream
    reset_n = 0; tick(); reset_n = 1;
    @(negedge clk);
    chk("mid_rst_tready", s_axis_tready, 0);
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_counts", {underrun_count, misalign_count}, 0);
    chk("mid_rst_streaming", streaming, 0);
    @(posedge clk); #1;

    // Counter saturation and clear priority
    fill_mode = 2'b01;
    for (int i = 1; i <= 4; i++) push_pair(i);
    tick();
    for (int i = 0; i < 4; i++) pulse_ready();
    m_axis_tready = 1;
    repeat (300) tick();
    @(negedge clk);
    chk("sat_underrun", underrun_count, 64'(CMAX));
    @(posedge clk); #1;
    clear_counters = 1; tick(); clear_counters = 0;
    @(negedge clk);
    chk("clear_wins", underrun_count, 0);
    @(posedge clk); #1;
    m_axis_tready = 0;

    // Randomized traffic
    ph = 0;
    for (int c = 0; c < 4000; c++) begin
      reset_n        = ($urandom_range(0, 799) != 0);
      s_axis_tvalid  = ($urandom_range(0, 3) != 0);
      s_axis_tdata   = $urandom();
      s_axis_tlast   = ph ^ ($urandom_range(0, 19) == 0);
      m_axis_tready  = ($urandom_range(0, 9) < (((c / 500) % 2) ? 2 : 7));
      flush          = ($urandom_range(0, 149) == 0);
      clear_counters = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) fill_mode = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) ph = ~s_axis_tlast;
      @(posedge clk); #1;
    end
    reset_n = 1; s_axis_tvalid = 0; m_axis_tready = 0; flush = 0; clear_counters = 0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
